// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory/peripheral bus between the IF port
// (requester 0) and the MEM port (requester 1). Each transaction goes
// IDLE -> BUSY (bus phase, waits on bus_ready) -> DONE (one-cycle ack).
// The winner's addr/wdata/we are captured at grant and held for the whole
// transaction, so requesters cannot disturb the bus mid-phase.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : ties go to the requester not granted last (pointer = 1 at
//               reset, so requester 0 wins the first tie)
//   undefined : fixed priority, requester 1 (MEM) wins every tie
module mem_bus_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   // requester 0 (instruction fetch)
   input  logic             req0,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] wdata0,
   input  logic             we0,
   // requester 1 (data access)
   input  logic             req1,
   input  logic [WIDTH-1:0] addr1,
   input  logic [WIDTH-1:0] wdata1,
   input  logic             we1,
   // grant / completion
   output logic             gnt0,
   output logic             gnt1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] rdata,
   // shared bus
   output logic             bus_valid,
   output logic [WIDTH-1:0] bus_addr,
   output logic [WIDTH-1:0] bus_wdata,
   output logic             bus_we,
   output logic             bus_sel,
   input  logic             bus_ready,
   input  logic [WIDTH-1:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic             any_req;
   logic             winner;

   assign any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
   // Index of the requester granted most recently; 1 at reset so that
   // requester 0 takes the first tie.
   logic ptr_q, ptr_d;

   // Tie goes to whoever was not granted last; a lone request always wins.
   always_comb begin
      winner = req1;
      if (req0 && req1) begin
         winner = ~ptr_q;
      end
   end

   // Pointer follows every grant, tie or not.
   always_comb begin
      ptr_d = ptr_q;
      if ((state_q == IDLE) && any_req) begin
         ptr_d = winner;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: MEM port beats IF port whenever both request.
   always_comb begin
      winner = req1;
   end
`endif

   // Next-state and bus capture: latch the winner on grant, capture read
   // data on slave completion, otherwise hold everything.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = BUSY;
               sel_d   = winner;
               addr_d  = winner ? addr1  : addr0;
               wdata_d = winner ? wdata1 : wdata0;
               we_d    = winner ? we1    : we0;
            end
         end
         BUSY: begin
            // No timeout: a slave that never answers holds the bus.
            if (bus_ready) begin
               rdata_d = bus_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            // Ack cycle only; arbitration resumes from IDLE so a held
            // request is treated as a fresh transaction.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and bus registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   // Decoded outputs: grant spans BUSY and DONE, ack is DONE only; both
   // are steered by the owner index so only one side can ever be high.
   always_comb begin
      gnt0      = (state_q != IDLE) && !sel_q;
      gnt1      = (state_q != IDLE) &&  sel_q;
      ack0      = (state_q == DONE) && !sel_q;
      ack1      = (state_q == DONE) &&  sel_q;
      bus_valid = (state_q == BUSY);
      bus_sel   = sel_q;
      bus_addr  = addr_q;
      bus_wdata = wdata_q;
      bus_we    = we_q;
      rdata     = rdata_q;
   end

   // Mutual exclusion of grants and acks.
   a_one_gnt : assert property (@(posedge clk) disable iff (!rst_n)
      !(gnt0 && gnt1));
   a_one_ack : assert property (@(posedge clk) disable iff (!rst_n)
      !(ack0 && ack1));

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares one memory/peripheral bus between the instruction-fetch port (requester 0) and the data-access port (requester 1) of the MIPS246 pipeline. It sequences each transaction as request → bus phase → acknowledge, latches the winner's address/data/write-enable onto the shared bus, and drives the select line of the downstream 2:1 bus multiplexers. It sits between the IF/MEM stages and the shared RAM/LED/segment bus.

## Interface

- WIDTH, 32, address/data width of each requester and the shared bus
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 (IF) transaction request, level
- addr0  in  WIDTH  requester 0 address
- wdata0  in  WIDTH  requester 0 write data
- we0  in  1  requester 0 write enable
- req1  in  1  requester 1 (MEM) transaction request, level
- addr1  in  WIDTH  requester 1 address
- wdata1  in  WIDTH  requester 1 write data
- we1  in  1  requester 1 write enable
- gnt0 / gnt1  out  1  requester owns the bus (BUSY and DONE)
- ack0 / ack1  out  1  one-cycle completion pulse to owner
- rdata  out  WIDTH  registered read data, valid while ack is high
- bus_valid  out  1  shared-bus transaction valid
- bus_addr  out  WIDTH  registered address of the owner
- bus_wdata  out  WIDTH  registered write data of the owner
- bus_we  out  1  registered write enable of the owner
- bus_sel  out  1  index of owner; drives downstream mux select
- bus_ready  in  1  slave completes current transaction this cycle
- bus_rdata  in  WIDTH  slave read data, sampled when bus_ready is high

## Operation

- States: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: if req0|req1, pick winner (arbitration below); latch winner's addr/wdata/we into bus_addr/bus_wdata/bus_we, set bus_sel=winner, gnt[winner]=1, bus_valid=1, → BUSY. No request: stay, bus_valid=0.
- BUSY: bus outputs held stable regardless of req/addr changes. When bus_ready=1: rdata←bus_rdata (reads and writes alike), ack[winner]=1, bus_valid=0, → DONE. bus_ready=0: stay (no timeout).
- DONE: ack high exactly this cycle; no arbitration; gnt held; → IDLE. Requester must drop or renew req by the edge ending DONE; a still-high req in IDLE is a new transaction.
- Requesters hold req and addr/wdata/we stable from assertion until ack; req deassertion before grant withdraws the request without side effect.
- bus_sel, bus_addr, bus_wdata, bus_we, rdata keep last value in IDLE; gnt0/gnt1/ack0/ack1/bus_valid are 0 in IDLE.
- At most one of gnt0/gnt1 and one of ack0/ack1 high at any time.

## Timing

- Reset values: gnt0=gnt1=ack0=ack1=bus_valid=bus_we=0, bus_sel=0, bus_addr=bus_wdata=rdata=0, last-owner pointer=1.
- rst_n low mid-transaction: all outputs to reset values immediately (asynchronous); transaction abandoned, no ack.
- req sampled high at edge N (IDLE) → BUSY from N: bus_valid/gnt high in cycle after N.
- bus_ready high at edge M (BUSY) → ack and rdata valid in cycle after M; IDLE after M+1.
- Zero-wait slave (bus_ready tied high): 3 cycles per transaction, back-to-back requests each 3 cycles.
- bus_ready ignored outside BUSY.

## Configuration

- ARB_ROUND_ROBIN_EN defined: on simultaneous req0&req1 in IDLE, grant the requester not granted last (pointer updated on every grant; pointer=1 at reset, so requester 0 wins first tie). Single request always granted.
- Not defined: fixed priority, requester 1 (MEM) always wins ties; pointer unused. Requester 0 may starve under continuous req1.

## Test plan

- Single read: req0=1, addr0=0x00000040, bus_ready=1, bus_rdata=0x2402000A → bus_addr=0x40, bus_sel=0, bus_we=0 one cycle after request; ack0 pulse with rdata=0x2402000A two cycles after; IDLE after three.
- Wait states: req1 write addr1=0x10000000, wdata1=0xFF, we1=1, bus_ready low 4 cycles → bus outputs stable for 5 BUSY cycles, single ack1, gnt1 high 6 cycles.
- Simultaneous requests, continuously held: with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it grant 1 on every transaction, ack0 never.
- Request changes mid-transaction: addr1 changes 0x20→0x24 during BUSY → bus_addr stays 0x20.
- Reset mid-BUSY: rst_n low during BUSY → gnt/bus_valid/bus_sel 0 at once, no ack; after release, req0 high granted normally.
- Held req after ack: req0 kept high through DONE → second transaction starts from IDLE, bus_valid gap of exactly 2 cycles.
